// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory controller.
// Holds the response error codes, controller states and the poison read word.
package dmem_pkg;

   typedef enum logic [1:0] {
      ERR_OK       = 2'b00,
      ERR_OOB      = 2'b01,
      ERR_CONFLICT = 2'b10
   } rsp_err_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RESP  = 2'b01,
      S_CLEAR = 2'b10
   } state_e;

   localparam logic [63:0] POISON_WORD = 64'hDEADBEEFDEADBEEF;

   // A request must be exactly one of read or write; that check outranks the range check.
   function automatic rsp_err_e classify_req(input logic rd, input logic wr, input logic oob);
      if (rd == wr) begin
         return ERR_CONFLICT;
      end
      if (oob) begin
         return ERR_OOB;
      end
      return ERR_OK;
   endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between the memory stage (master) and the data memory (slave).
// Both directions use a valid/ready handshake.
interface dmem_if
   import dmem_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 16
);

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_rd;
   logic                  req_wr;
   logic [ADDR_W-1:0]     req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic [DATA_W/8-1:0]   req_wstrb;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_W-1:0]     rsp_rdata;
   rsp_err_e              rsp_err;

   modport master (
      output req_valid, req_rd, req_wr, req_addr, req_wdata, req_wstrb, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_rd, req_wr, req_addr, req_wdata, req_wstrb, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage built from one byte-wide RAM per lane so each strobe maps
// directly onto a lane write enable; the read port is registered and only loads on re.
module dmem_array #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 32768,
   parameter int AW     = 15
) (
   input  logic                clk,
   input  logic                we,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic [AW-1:0]       waddr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic                re,
   input  logic [AW-1:0]       raddr,
   output logic [DATA_W-1:0]   rdata
);

   genvar gi;
   generate
      for (gi = 0; gi < DATA_W / 8; gi++) begin : g_lane
         logic [7:0] lane_mem [DEPTH];
         logic [7:0] rd_byte_q;

         always_ff @(posedge clk) begin
            if (we && wstrb[gi]) begin
               lane_mem[waddr] <= wdata[gi*8 +: 8];
            end
            if (re) begin
               rd_byte_q <= lane_mem[raddr];
            end
         end

         assign rdata[gi*8 +: 8] = rd_byte_q;
      end
   endgenerate

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: handshake FSM, request checks, sticky flags and error counter.
// Optional DMEM_CLEAR_ON_RESET_EN zeroes the whole array after reset before serving requests.
module data_mem_ctrl
   import dmem_pkg::*;
#(
   parameter int          DATA_W = 64,
   parameter int          ADDR_W = 16,
   parameter int          DEPTH  = 32768,
   parameter int          CNT_W  = 8,
   parameter logic [63:0] POISON = POISON_WORD
) (
   input  logic             clk,
   input  logic             rst_n,
   dmem_if.slave            bus,
   input  logic             clr_flags,
   output logic             oob_sticky,
   output logic             conflict_sticky,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int              STRB_W   = DATA_W / 8;
   localparam int              MEM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W + 1)'(DEPTH);
   localparam logic [DATA_W-1:0] POISON_D = DATA_W'(POISON);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
`ifdef DMEM_CLEAR_ON_RESET_EN
   localparam state_e RESET_STATE = S_CLEAR;
`else
   localparam state_e RESET_STATE = S_IDLE;
`endif

   state_e           state_q, state_d;
   logic             rsp_valid_q, rsp_valid_d;
   rsp_err_e         rsp_err_q, rsp_err_d;
   logic             rsp_rd_q, rsp_rd_d;
   logic             oob_q, oob_d;
   logic             conf_q, conf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic              accept;
   logic              req_oob;
   rsp_err_e          req_err;
   logic              req_ok;
   logic [MEM_AW-1:0] req_idx;

   logic              mem_we;
   logic              mem_re;
   logic [STRB_W-1:0] mem_wstrb;
   logic [MEM_AW-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // Ready is combinational on rsp_ready so a held response can retire and be replaced
   // on the same edge, giving one access per cycle.
   assign bus.req_ready = rst_n && ((state_q == S_IDLE) ||
                                    ((state_q == S_RESP) && bus.rsp_ready));
   assign accept  = bus.req_valid && bus.req_ready;
   assign req_oob = {1'b0, bus.req_addr} >= DEPTH_X;
   assign req_err = classify_req(bus.req_rd, bus.req_wr, req_oob);
   assign req_ok  = (req_err == ERR_OK);
   assign req_idx = bus.req_addr[MEM_AW-1:0];
   assign mem_re  = accept && bus.req_rd && req_ok;

`ifdef DMEM_CLEAR_ON_RESET_EN
   logic [MEM_AW-1:0] clr_addr_q, clr_addr_d;
   logic              clearing;

   assign clearing = (state_q == S_CLEAR);

   // The sweep owns the write port; no request can be accepted while it runs.
   always_comb begin
      mem_we    = clearing || (accept && bus.req_wr && req_ok);
      mem_waddr = clearing ? clr_addr_q : req_idx;
      mem_wdata = clearing ? '0 : bus.req_wdata;
      mem_wstrb = clearing ? '1 : bus.req_wstrb;
   end
`else
   always_comb begin
      mem_we    = accept && bus.req_wr && req_ok;
      mem_waddr = req_idx;
      mem_wdata = bus.req_wdata;
      mem_wstrb = bus.req_wstrb;
   end
`endif

   dmem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (MEM_AW)
   ) u_array (
      .clk    (clk),
      .we     (mem_we),
      .wstrb  (mem_wstrb),
      .waddr  (mem_waddr),
      .wdata  (mem_wdata),
      .re     (mem_re),
      .raddr  (req_idx),
      .rdata  (mem_rdata)
   );

   always_comb begin
      state_d     = state_q;
      rsp_err_d   = rsp_err_q;
      rsp_rd_d    = rsp_rd_q;
      oob_d       = oob_q;
      conf_d      = conf_q;
      cnt_d       = cnt_q;
`ifdef DMEM_CLEAR_ON_RESET_EN
      clr_addr_d  = clr_addr_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (!accept && bus.rsp_ready) begin
               state_d = S_IDLE;
            end
         end
`ifdef DMEM_CLEAR_ON_RESET_EN
         S_CLEAR: begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == MEM_AW'(DEPTH - 1)) begin
               state_d = S_IDLE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      if (accept) begin
         rsp_err_d = req_err;
         rsp_rd_d  = bus.req_rd && req_ok;
      end

      // Clear first so an error on the same edge still lands in the flags and counter.
      if (clr_flags) begin
         oob_d  = 1'b0;
         conf_d = 1'b0;
         cnt_d  = '0;
      end
      if (accept && !req_ok) begin
         if (req_err == ERR_OOB) begin
            oob_d = 1'b1;
         end else begin
            conf_d = 1'b1;
         end
         if (cnt_d != CNT_MAX) begin
            cnt_d = cnt_d + 1'b1;
         end
      end

      rsp_valid_d = (state_d == S_RESP);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= RESET_STATE;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= ERR_OK;
         rsp_rd_q    <= 1'b0;
         oob_q       <= 1'b0;
         conf_q      <= 1'b0;
         cnt_q       <= '0;
`ifdef DMEM_CLEAR_ON_RESET_EN
         clr_addr_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rd_q    <= rsp_rd_d;
         oob_q       <= oob_d;
         conf_q      <= conf_d;
         cnt_q       <= cnt_d;
`ifdef DMEM_CLEAR_ON_RESET_EN
         clr_addr_q  <= clr_addr_d;
`endif
      end
   end

   // Read data lives in the array's output register, which only reloads on a good read,
   // so the response stays stable while stalled.
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = !rsp_valid_q          ? '0       :
                          (rsp_err_q != ERR_OK) ? POISON_D :
                          rsp_rd_q              ? mem_rdata : '0;

   assign oob_sticky      = oob_q;
   assign conflict_sticky = conf_q;
   assign err_cnt         = cnt_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: a per-cycle compare against a word-level memory model
// plus literal expectations for each scenario.
module tb_data_mem_ctrl;
   import dmem_pkg::*;

   localparam int DATA_W = 64;
   localparam int ADDR_W = 16;
   localparam int DEPTH  = 32768;
   localparam int CNT_W  = 8;
`ifdef DMEM_CLEAR_ON_RESET_EN
   localparam bit CLR_EN = 1'b1;
`else
   localparam bit CLR_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             clr_flags = 1'b0;
   logic             oob_sticky;
   logic             conflict_sticky;
   logic [CNT_W-1:0] err_cnt;

   dmem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   data_mem_ctrl #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .bus             (bus),
      .clr_flags       (clr_flags),
      .oob_sticky      (oob_sticky),
      .conflict_sticky (conflict_sticky),
      .err_cnt         (err_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [63:0] rdata;
      logic [1:0]  err;
      bit          chk_data;
   } exp_t;

   exp_t        exp_q[$];
   logic [63:0] mem_m [int];
   bit          mem_zeroed = 1'b0;
   bit          oob_m = 1'b0;
   bit          conf_m = 1'b0;
   int          cnt_m = 0;
   int          clear_left = 0;
   bit          armed = 1'b0;

   always @(negedge clk) begin
      bit          exp_ready;
      exp_t        e;
      logic [63:0] word;
      int          a;

      exp_ready = rst_n && (clear_left == 0) && ((exp_q.size() == 0) || bus.rsp_ready);
      if (armed) begin
         chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
         chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            chk("rsp_err", 64'(bus.rsp_err), 64'(exp_q[0].err));
            if (exp_q[0].chk_data) chk("rsp_rdata", bus.rsp_rdata, exp_q[0].rdata);
         end
         chk("oob_sticky", 64'(oob_sticky), 64'(oob_m));
         chk("conflict_sticky", 64'(conflict_sticky), 64'(conf_m));
         chk("err_cnt", 64'(err_cnt), 64'(cnt_m));
      end

      // Effects of the coming rising edge.
      if (!rst_n) begin
         exp_q.delete();
         oob_m  = 1'b0;
         conf_m = 1'b0;
         cnt_m  = 0;
         if (CLR_EN) begin
            clear_left = DEPTH;
            mem_m.delete();
            mem_zeroed = 1'b1;
         end
         armed = 1'b1;
      end else begin
         if (clear_left > 0) clear_left--;
         if ((exp_q.size() != 0) && bus.rsp_ready) void'(exp_q.pop_front());
         if (clr_flags) begin
            oob_m  = 1'b0;
            conf_m = 1'b0;
            cnt_m  = 0;
         end
         if (bus.req_valid && exp_ready) begin
            a = int'(bus.req_addr);
            e.chk_data = 1'b1;
            e.rdata    = 64'h0;
            if (bus.req_rd == bus.req_wr) e.err = 2'd2;
            else if (a >= DEPTH)          e.err = 2'd1;
            else                          e.err = 2'd0;
            if (e.err != 2'd0) begin
               e.rdata = 64'hDEADBEEFDEADBEEF;
               if (e.err == 2'd1) oob_m = 1'b1;
               else               conf_m = 1'b1;
               if (cnt_m < 255) cnt_m++;
            end else if (bus.req_wr) begin
               word = mem_m.exists(a) ? mem_m[a] : (mem_zeroed ? 64'h0 : 'x);
               for (int b = 0; b < 8; b++) begin
                  if (bus.req_wstrb[b]) word[b*8 +: 8] = bus.req_wdata[b*8 +: 8];
               end
               mem_m[a] = word;
            end else begin
               word = mem_m.exists(a) ? mem_m[a] : (mem_zeroed ? 64'h0 : 'x);
               e.rdata    = word;
               e.chk_data = !$isunknown(word);
            end
            exp_q.push_back(e);
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [63:0] lit_rdata;
   logic [1:0]  lit_err;

   task automatic drive_idle();
      bus.req_valid = 1'b0;
      bus.req_rd    = 1'b0;
      bus.req_wr    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_wstrb = '0;
   endtask

   task automatic wait_ready(input int limit, output int n);
      n = 0;
      while (!bus.req_ready && n < limit) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.req_ready) chk("ready_timeout", 64'(bus.req_ready), 64'd1);
   endtask

   task automatic issue(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [63:0] wdata, input logic [7:0] wstrb);
      int n;
      bus.req_valid = 1'b1;
      bus.req_rd    = rd;
      bus.req_wr    = wr;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_wstrb = wstrb;
      wait_ready(100, n);
      @(posedge clk); #1;
      drive_idle();
      lit_rdata = bus.rsp_rdata;
      lit_err   = bus.rsp_err;
   endtask

   initial begin
      int n;
      drive_idle();
      bus.rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("reset_rsp_rdata", bus.rsp_rdata, 64'd0);
      chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
      chk("reset_err_cnt", 64'(err_cnt), 64'd0);
      rst_n = 1'b1;
      wait_ready(40000, n);
      if (CLR_EN) chk("clear_cycles", 64'(n), 64'(DEPTH));

      // 1: full write then read-after-write
      issue(1'b0, 1'b1, 16'h0010, 64'h123456789ABCDEF0, 8'hFF);
      chk("t1_wr_err", 64'(lit_err), 64'd0);
      chk("t1_wr_rdata", lit_rdata, 64'd0);
      issue(1'b1, 1'b0, 16'h0010, 64'h0, 8'h00);
      chk("t1_rd_rdata", lit_rdata, 64'h123456789ABCDEF0);
      chk("t1_rd_err", 64'(lit_err), 64'd0);

      // 2: partial strobe
      issue(1'b0, 1'b1, 16'h0010, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
      issue(1'b1, 1'b0, 16'h0010, 64'h0, 8'h00);
      chk("t2_rd_rdata", lit_rdata, 64'h12345678FFFFFFFF);

      // 3: out of bound
      issue(1'b1, 1'b0, 16'h8000, 64'h0, 8'h00);
      chk("t3_rdata", lit_rdata, 64'hDEADBEEFDEADBEEF);
      chk("t3_err", 64'(lit_err), 64'd1);
      chk("t3_oob", 64'(oob_sticky), 64'd1);
      chk("t3_cnt", 64'(err_cnt), 64'd1);
      issue(1'b0, 1'b1, 16'hFFFF, 64'h0, 8'hFF);
      chk("t3_wr_oob_err", 64'(lit_err), 64'd1);

      // 4: rd/wr conflict, both set and both clear
      issue(1'b1, 1'b1, 16'h0010, 64'h0, 8'hFF);
      chk("t4_err", 64'(lit_err), 64'd2);
      chk("t4_conflict", 64'(conflict_sticky), 64'd1);
      issue(1'b0, 1'b0, 16'h8000, 64'h0, 8'h00);
      chk("t4_none_err", 64'(lit_err), 64'd2);
      chk("t4_cnt", 64'(err_cnt), 64'd4);
      issue(1'b0, 1'b1, 16'h0010, 64'hAAAAAAAAAAAAAAAA, 8'h00);
      chk("t4_nostrb_err", 64'(lit_err), 64'd0);
      issue(1'b1, 1'b0, 16'h0010, 64'h0, 8'h00);
      chk("t4_rd_rdata", lit_rdata, 64'h12345678FFFFFFFF);

      // clear together with an error: the error is counted
      clr_flags = 1'b1;
      issue(1'b1, 1'b1, 16'h0020, 64'h0, 8'h00);
      clr_flags = 1'b0;
      chk("clr_err_cnt", 64'(err_cnt), 64'd1);
      chk("clr_err_oob", 64'(oob_sticky), 64'd0);

      // saturation
      for (int i = 0; i < 260; i++) issue(1'b1, 1'b1, 16'h0000, 64'h0, 8'h00);
      chk("sat_cnt", 64'(err_cnt), 64'd255);
      clr_flags = 1'b1;
      @(posedge clk); #1;
      clr_flags = 1'b0;
      chk("clr_cnt", 64'(err_cnt), 64'd0);

      // 5: backpressure with a queued request
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_rd    = 1'b1;
      bus.req_addr  = 16'h0010;
      @(posedge clk); #1;
      bus.req_addr = 16'h8000;
      for (int i = 0; i < 3; i++) begin
         chk("t5_stall_ready", 64'(bus.req_ready), 64'd0);
         chk("t5_stall_rdata", bus.rsp_rdata, 64'h12345678FFFFFFFF);
         @(posedge clk); #1;
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      drive_idle();
      chk("t5_b2b_valid", 64'(bus.rsp_valid), 64'd1);
      chk("t5_b2b_rdata", bus.rsp_rdata, 64'hDEADBEEFDEADBEEF);
      @(posedge clk); #1;
      chk("t5_drained", 64'(bus.rsp_valid), 64'd0);

      // 6: reset while a response is held
      bus.rsp_ready = 1'b0;
      issue(1'b1, 1'b1, 16'h0010, 64'h0, 8'h00);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("t6_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("t6_conflict", 64'(conflict_sticky), 64'd0);
      chk("t6_cnt", 64'(err_cnt), 64'd0);
      chk("t6_ready_in_reset", 64'(bus.req_ready), 64'd0);
      bus.rsp_ready = 1'b1;
      rst_n = 1'b1;
      wait_ready(40000, n);
      if (CLR_EN) chk("t6_clear_cycles", 64'(n), 64'(DEPTH));
      issue(1'b1, 1'b0, 16'h0010, 64'h0, 8'h00);
      chk("t6_rd_rdata", lit_rdata, CLR_EN ? 64'h0 : 64'h12345678FFFFFFFF);

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
